// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
// Used by univ_shift_reg, usr_cell and the interface users.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(
    input logic [1:0] m
  );
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// master drives controls and data, slave is the register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic             rot;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, sin_r, sin_l,
    output rot, start, cnt,
    input  q, qb, sout, busy, done
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    input  rot, start, cnt,
    output q, qb, sout, busy, done
  );

endinterface

// File: rtl/usr_cell.sv
// One bit of the universal shift register: 4:1 mux feeding a flop.
// i_hi is the bit entering on a right shift, i_lo on a left shift.
module usr_cell
  import univ_shift_reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_op,
  input  logic       i_hi,
  input  logic       i_lo,
  input  logic       i_d,
  output logic       o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_BIT;
    end else begin
      case (i_op)
        MODE_HOLD: r_q <= r_q;
        MODE_SHR:  r_q <= i_hi;
        MODE_SHL:  r_q <= i_lo;
        default:   r_q <= i_d;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and burst shifting.
// Define USR_ROTATE_EN to let rot turn shifts into rotates.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  univ_shift_reg_if.slave  sr
);

  state_t           r_st;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_sout;
  logic [1:0]       w_op;
  logic             w_go;
  logic             w_rot;
  logic             w_sr;
  logic             w_sl;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_go = (r_st == IDLE) && sr.start &&
                (sr.cnt != '0) && is_shift(sr.mode);

  always_comb begin
    w_nxt = r_st;
    w_op  = MODE_HOLD;
    unique case (r_st)
      IDLE: begin
        if (w_go)       w_nxt = SHIFT;
        else if (sr.en) w_op  = sr.mode;
      end
      SHIFT: begin
        w_op = r_mode;
        if (r_cnt <= CNT_W'(1)) w_nxt = DONE;
      end
      DONE: begin
        w_nxt = IDLE;
        if (sr.en) w_op = sr.mode;
      end
      default: w_nxt = IDLE;
    endcase
  end

`ifdef USR_ROTATE_EN
  logic r_rot;

  assign w_rot = (r_st == SHIFT) ? r_rot : sr.rot;

  always_ff @(posedge clk) begin
    if (rst)       r_rot <= 1'b0;
    else if (w_go) r_rot <= sr.rot;
  end
`else
  logic w_unused_rot;

  assign w_rot        = 1'b0;
  assign w_unused_rot = sr.rot;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_mode <= MODE_HOLD;
      r_sout <= 1'b0;
    end else begin
      r_st <= w_nxt;
      if (w_go) begin
        r_cnt  <= sr.cnt;
        r_mode <= sr.mode;
      end else if (r_st == SHIFT) begin
        r_cnt  <= r_cnt - CNT_W'(1);
      end
      if (w_op == MODE_SHR)      r_sout <= w_q[0];
      else if (w_op == MODE_SHL) r_sout <= w_q[WIDTH-1];
    end
  end

  // Serial entry bits; a rotate feeds back the bit leaving the far end.
  assign w_sr = w_rot ? w_q[0]       : sr.sin_r;
  assign w_sl = w_rot ? w_q[WIDTH-1] : sr.sin_l;
  assign w_hi = {w_sr, w_q[WIDTH-1:1]};
  assign w_lo = {w_q[WIDTH-2:0], w_sl};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .i_op (w_op),
      .i_hi (w_hi[i]),
      .i_lo (w_lo[i]),
      .i_d  (sr.d[i]),
      .o_q  (w_q[i])
    );
  end

  assign sr.q    = w_q;
  assign sr.qb   = ~w_q;
  assign sr.sout = r_sout;
  assign sr.busy = (r_st == SHIFT);
  assign sr.done = (r_st == DONE);

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2..64.
REQ-002 Parameter CNT_W, default 4: width of the burst-count input.
REQ-003 Parameter RST_VAL, default 0: value loaded into q on reset.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  single-step enable, effective only when busy=0.
REQ-007 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial input entering the MSB on a right shift.
REQ-010 sin_l  input  1  serial input entering the LSB on a left shift.
REQ-011 rot  input  1  rotate request; ignored unless USR_ROTATE_EN is defined.
REQ-012 start  input  1  burst request: perform cnt shifts in the direction given by mode.
REQ-013 cnt  input  CNT_W  burst length, sampled with start.
REQ-014 q  output  WIDTH  register contents.
REQ-015 qb  output  WIDTH  bitwise complement of q, always equal to ~q in the same cycle.
REQ-016 sout  output  1  bit shifted out by the most recent shift (LSB on right shift, MSB on left shift), registered.
REQ-017 busy  output  1  high while a burst is in progress.
REQ-018 done  output  1  one-cycle pulse on the cycle after the last burst shift.

Function
REQ-019 Single step (busy=0, start=0, en=1): q updates one cycle after the clock edge per mode; mode 00 holds q; mode 11 sets q=d.
REQ-020 Right shift sets q={sin_r, q[WIDTH-1:1]} and sout=q[0]; left shift sets q={q[WIDTH-2:0], sin_l} and sout=q[WIDTH-1].
REQ-021 With en=0 and no burst active, q, sout and done hold their values.
REQ-022 FSM states: IDLE, SHIFT, DONE.
REQ-023 Transitions: IDLE->SHIFT on start=1 with cnt!=0 and mode in {01,10}; SHIFT->DONE when the remaining count reaches 0; DONE->IDLE unconditionally.
REQ-024 In SHIFT, mode and the rot sampled at start are latched; one shift occurs per cycle regardless of en, mode or rot, giving exactly cnt shifts over cnt cycles.
REQ-025 busy=1 in SHIFT only; done=1 in DONE only.
REQ-026 start with cnt=0, or with mode 00 or 11, is treated as a single step gated by en; no burst begins and done does not pulse.
REQ-027 start, en, d and mode are ignored while busy=1.
REQ-028 start asserted in DONE is ignored; a new burst requires start in IDLE.
REQ-029 The remaining-count register is CNT_W bits and decrements with no wrap; the maximum burst is 2^CNT_W-1 shifts.

Reset
REQ-030 rst=1 at a posedge sets q=RST_VAL, qb=~RST_VAL, sout=0, busy=0, done=0, FSM=IDLE, and remaining count=0.
REQ-031 rst has priority over all inputs and aborts a burst mid-operation; no done pulse follows an aborted burst.

Configuration
REQ-032 Macro USR_ROTATE_EN: when defined, rot=1 makes shifts rotate (right: q={q[0],q[WIDTH-1:1]}; left: q={q[WIDTH-2:0],q[WIDTH-1]}), ignoring sin_r and sin_l; sout still reports the bit moved.
REQ-033 When USR_ROTATE_EN is not defined, the rot port is present but unused and all shifts take sin_r or sin_l.

Structure
REQ-034 Shared package univ_shift_reg_pkg holds the mode encoding constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the FSM state type.
REQ-035 One sub-module, usr_cell, implements the per-bit 4:1 mux plus flop; it is instantiated WIDTH times, and the FSM and counter stay in the top module.

Verification
REQ-036 WIDTH=8, rst -> q=00, qb=FF, busy=0, done=0.
REQ-037 mode=11, d=A5, en=1 -> q=A5, qb=5A; then mode=01, sin_r=1 -> q=D2, sout=1.
REQ-038 q=81, mode=10, start=1, cnt=3, sin_l=0 -> busy high for 3 cycles, then q=08, done pulses once, busy=0.
REQ-039 Burst with cnt=5, rst asserted in the 2nd shift cycle -> q=00, busy=0, FSM=IDLE, done never pulses.
REQ-040 With USR_ROTATE_EN defined: q=81, mode=01, rot=1, en=1 -> q=C0, sout=1; without the macro, sin_r=0 -> q=40.
REQ-041 start with cnt=0, mode=01, en=0 -> q unchanged, busy=0, done=0.
